switch_host_tx: RTL

//  Host-side transmitter for one port of the 4-port switch. Accepts packets from local logic over a

---
 rtl/switch_host_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/switch_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : switch_host_tx
//  Purpose  : Host-side transmitter for one switch port. It buffers requests in
//             a FIFO and drives one-cycle ingress pulses with a programmable gap.
//  Revision : 1.0
// ============================================================================
module switch_host_tx #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] PORT_ID    = 4'b0001,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    MIN_GAP    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_target,
    input  logic [DATA_WIDTH-1:0]         req_data,
    output logic                          tx_valid,
    output logic [ADDR_WIDTH-1:0]         tx_source,
    output logic [ADDR_WIDTH-1:0]         tx_target,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [15:0]                   sent_cnt,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(MIN_GAP + 2);
    localparam logic [GW-1:0] c_gap_init = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [ADDR_WIDTH-1:0] r_mem_target [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data   [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_gap;
    logic [GW-1:0]         w_gap_nxt;

    logic w_full;
    logic w_empty;
    logic w_onehot;
    logic w_legal;
    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_can_launch;
    logic w_pop;

    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign req_ready  = !w_full;
    assign fifo_level = r_count;
    assign tx_source  = PORT_ID;

    // A request is legal only when exactly one target bit is set and it is not our own port.
    assign w_onehot = (req_target != '0) && ((req_target & (req_target - 1'b1)) == '0);
    assign w_legal  = w_onehot && (req_target != PORT_ID);
    assign w_accept = req_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_drop   = w_accept && !w_legal;

    assign w_can_launch = tx_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_target[r_wr_ptr] <= req_target;
            r_mem_data[r_wr_ptr]   <= req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // When the gap expires the FSM may launch directly, keeping throughput at 1/(1+MIN_GAP).
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_launch) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (MIN_GAP > 0) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = c_gap_init;
                end else if (w_can_launch) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_gap != '0) begin
                    w_gap_nxt = r_gap - 1'b1;
                end else if (w_can_launch) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gap     <= '0;
            tx_valid  <= 1'b0;
            tx_target <= '0;
            tx_data   <= '0;
            sent_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gap    <= w_gap_nxt;
            tx_valid <= w_pop;
            if (w_pop) begin
                tx_target <= r_mem_target[r_rd_ptr];
                tx_data   <= r_mem_data[r_rd_ptr];
                sent_cnt  <= sent_cnt + 1'b1;
            end else begin
                tx_target <= '0;
                tx_data   <= '0;
            end
        end
    end

endmodule
`default_nettype wire
